// File: rtl/cache_if_pkg.sv
// Shared definitions for the cache memory-side responder.
//   - access type codes used on rd_type / wr_type
//   - default line geometry (WORDS_PER_LINE, OFFSET_WIDTH)
//   - responder FSM state encoding
//   - helper that flags reserved type codes
package cache_if_pkg;

  localparam logic [2:0] RD_TYPE_BYTE = 3'd0;
  localparam logic [2:0] RD_TYPE_HALF = 3'd1;
  localparam logic [2:0] RD_TYPE_WORD = 3'd2;
  localparam logic [2:0] RD_TYPE_LINE = 3'd4;

  localparam int BYTES_PER_LINE_DEF = 64;
  localparam int WORDS_PER_LINE     = BYTES_PER_LINE_DEF / 4;
  localparam int OFFSET_WIDTH       = $clog2(BYTES_PER_LINE_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_WAIT,
    ST_WR_COMMIT
  } state_t;

  function automatic logic is_reserved(input logic [2:0] t);
    return !((t == RD_TYPE_BYTE) || (t == RD_TYPE_HALF) ||
             (t == RD_TYPE_WORD) || (t == RD_TYPE_LINE));
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache <-> memory refill bus.
//   master : cache side, drives rd_*/wr_* requests, receives rdy/ret/proto_err
//   slave  : memory responder side
// BYTES_PER_LINE sizes the writeback data bus (word 0 in bits [31:0]).
interface cache_mem_responder_if #(
  parameter int BYTES_PER_LINE = 64
);
  logic                          rd_req;
  logic [2:0]                    rd_type;
  logic [31:0]                   rd_addr;
  logic                          rd_rdy;
  logic                          ret_valid;
  logic                          ret_last;
  logic [31:0]                   ret_data;
  logic                          wr_req;
  logic [2:0]                    wr_type;
  logic [31:0]                   wr_addr;
  logic [3:0]                    wr_wstrb;
  logic [BYTES_PER_LINE*8-1:0]   wr_data;
  logic                          wr_rdy;
  logic                          proto_err;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, proto_err
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, proto_err
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) used for optional
// random latency jitter in the memory responder.
//   clk, resetn : clock, synchronous active-low reset (seed 16'hACE1)
//   en          : advance one step
//   q           : current LFSR state
module lfsr16 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= 16'hACE1;
    end else if (en) begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill interface.
// Serves line refills and uncached single reads as streams of 32-bit return
// beats, and absorbs dirty-line / single-word writebacks into a word memory.
// Words never written read back as ({idx,2'b00} ^ PAT_SEED).
//
// Ports:
//   clk    : clock
//   resetn : synchronous active-low reset; aborts any burst/commit in flight
//   bus    : cache_mem_responder_if.slave (rd/ret/wr channels, proto_err)
//
// Optional build macro CACHE_MEM_RAND_DELAY_EN: an LFSR adds 0..7 extra
// cycles before the first beat / first commit and 0..3 bubbles between
// line beats. Undefined: fixed latencies, no bubbles.
module cache_mem_responder
  import cache_if_pkg::*;
#(
  parameter int          BYTES_PER_LINE = BYTES_PER_LINE_DEF,
  parameter int          MEM_WORDS      = 4096,
  parameter int          RD_LATENCY     = 4,
  parameter int          WR_LATENCY     = 2,
  parameter logic [31:0] PAT_SEED       = 32'h5a5a_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  cache_mem_responder_if.slave  bus
);

  localparam int LINE_WORDS = BYTES_PER_LINE / 4;
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int LINE_W     = BYTES_PER_LINE * 8;
  localparam int CNT_W      = 16;

  localparam logic [IDX_W-1:0] LINE_MASK   = ~IDX_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] LINE_LEN    = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] RD_BASE_DLY = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_BASE_DLY = CNT_W'(WR_LATENCY - 1);

  state_t              state;
  logic [31:0]         mem [MEM_WORDS];
  logic [MEM_WORDS-1:0] word_vld;

  logic                ret_valid_q;
  logic                ret_last_q;
  logic [31:0]         ret_data_q;
  logic                proto_err_q;

  logic [IDX_W-1:0]    rd_idx;
  logic [CNT_W-1:0]    rd_left;
  logic [CNT_W-1:0]    wcnt;
  logic [1:0]          bub;

  logic [IDX_W-1:0]    wr_idx;
  logic [CNT_W-1:0]    wr_left;
  logic [CNT_W-1:0]    wr_cnt;
  logic [LINE_W-1:0]   wr_line;
  logic [3:0]          wr_strb;

  logic                idle, rd_rdy, wr_rdy, rd_acc, wr_acc;
  logic                rd_is_line, wr_is_line;
  logic [IDX_W-1:0]    rd_word_idx, wr_word_idx, rd_base, wr_base;
  logic [CNT_W-1:0]    rd_len, rd_dly, wr_dly;
  logic [IDX_W-1:0]    em_idx;
  logic [CNT_W-1:0]    em_left;
  logic                emit;
  logic                commit_en;
  logic [31:0]         commit_word;

  logic [2:0]          rd_extra, wr_extra;
  logic [1:0]          bub_rand;

`ifdef CACHE_MEM_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .q      (lfsr_q)
  );

  assign rd_extra    = lfsr_q[2:0];
  assign wr_extra    = lfsr_q[5:3];
  assign bub_rand    = lfsr_q[7:6];
  assign unused_lfsr = ^lfsr_q[15:8];
`else
  assign rd_extra = 3'd0;
  assign wr_extra = 3'd0;
  assign bub_rand = 2'd0;
`endif

  // Address bits outside the word index are ignored (addresses alias).
  logic unused_addr;
  assign unused_addr = ^{bus.rd_addr[31:IDX_W+2], bus.rd_addr[1:0],
                         bus.wr_addr[31:IDX_W+2], bus.wr_addr[1:0]};

  function automatic logic [31:0] pattern(input logic [IDX_W-1:0] idx);
    return (32'(idx) << 2) ^ PAT_SEED;
  endfunction

  function automatic logic [31:0] read_word(input logic [IDX_W-1:0] idx);
    return word_vld[idx] ? mem[idx] : pattern(idx);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    idle        = (state == ST_IDLE);
    // Write wins a same-cycle collision so a writeback lands before its refill.
    wr_rdy      = idle && resetn;
    rd_rdy      = idle && resetn && !bus.wr_req;
    wr_acc      = bus.wr_req && wr_rdy;
    rd_acc      = bus.rd_req && rd_rdy;

    rd_is_line  = (bus.rd_type == RD_TYPE_LINE);
    wr_is_line  = (bus.wr_type == RD_TYPE_LINE);
    rd_word_idx = bus.rd_addr[IDX_W+1:2];
    wr_word_idx = bus.wr_addr[IDX_W+1:2];
    rd_base     = rd_is_line ? (rd_word_idx & LINE_MASK) : rd_word_idx;
    wr_base     = wr_is_line ? (wr_word_idx & LINE_MASK) : wr_word_idx;
    rd_len      = rd_is_line ? LINE_LEN : CNT_W'(1);
    rd_dly      = RD_BASE_DLY + CNT_W'(rd_extra);
    wr_dly      = WR_BASE_DLY + CNT_W'(wr_extra);

    // A beat can be launched straight from the accept (zero extra wait),
    // from the end of the wait phase, or mid-burst after any bubbles.
    em_idx      = idle ? rd_base : rd_idx;
    em_left     = idle ? rd_len  : rd_left;
    emit        = (idle && rd_acc && (rd_dly == '0)) ||
                  ((state == ST_RD_WAIT) && (wcnt == CNT_W'(1))) ||
                  ((state == ST_RD_BURST) && !(ret_valid_q && ret_last_q) && (bub == '0));

    commit_en   = resetn && (state == ST_WR_COMMIT);
    commit_word = byte_merge(read_word(wr_idx), wr_line[32*int'(wr_cnt) +: 32], wr_strb);
  end

  assign bus.rd_rdy    = rd_rdy;
  assign bus.wr_rdy    = wr_rdy;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_last  = ret_last_q;
  assign bus.ret_data  = ret_data_q;
  assign bus.proto_err = proto_err_q;

  // Storage array: no reset; word_vld decides whether contents are live.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[wr_idx] <= commit_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      proto_err_q <= 1'b0;
      word_vld    <= '0;
      rd_idx      <= '0;
      rd_left     <= '0;
      wcnt        <= '0;
      bub         <= '0;
      wr_idx      <= '0;
      wr_left     <= '0;
      wr_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_acc) begin
            if (is_reserved(bus.wr_type)) proto_err_q <= 1'b1;
            wr_line <= bus.wr_data;
            wr_strb <= wr_is_line ? 4'hf : bus.wr_wstrb;
            wr_idx  <= wr_base;
            wr_left <= wr_is_line ? LINE_LEN : CNT_W'(1);
            wr_cnt  <= '0;
            if (wr_dly == '0) begin
              state <= ST_WR_COMMIT;
            end else begin
              wcnt  <= wr_dly;
              state <= ST_WR_WAIT;
            end
          end else if (rd_acc) begin
            if (is_reserved(bus.rd_type)) proto_err_q <= 1'b1;
            rd_idx  <= rd_base;
            rd_left <= rd_len;
            if (rd_dly == '0) begin
              state <= ST_RD_BURST;
            end else begin
              wcnt  <= rd_dly;
              state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (wcnt == CNT_W'(1)) state <= ST_RD_BURST;
          else                   wcnt  <= wcnt - 1'b1;
        end
        ST_RD_BURST: begin
          if (ret_valid_q && ret_last_q) begin
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            state       <= ST_IDLE;
          end else if (bub != '0) begin
            ret_valid_q <= 1'b0;
            bub         <= bub - 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (wcnt == CNT_W'(1)) state <= ST_WR_COMMIT;
          else                   wcnt  <= wcnt - 1'b1;
        end
        ST_WR_COMMIT: begin
          word_vld[wr_idx] <= 1'b1;
          wr_idx           <= wr_idx + 1'b1;
          wr_cnt           <= wr_cnt + 1'b1;
          wr_left          <= wr_left - 1'b1;
          if (wr_left == CNT_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (emit) begin
        ret_valid_q <= 1'b1;
        ret_data_q  <= read_word(em_idx);
        ret_last_q  <= (em_left == CNT_W'(1));
        rd_idx      <= em_idx + 1'b1;
        rd_left     <= em_left - 1'b1;
        bub         <= bub_rand;
        state       <= ST_RD_BURST;
      end
    end
  end

endmodule
